// File: rtl/bin_dilate.sv
// 3x3 binary dilation of a 0x00/0xFF edge map with vsync/hsync/valid framing.
// Optional BIN_DILATE_THRESH_EN binarises grey input against THRESH instead of != 0.
module bin_dilate #(
   parameter int IMG_WIDTH_MAX = 1024,
   parameter int THRESH        = 128
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pre_img_vsync,
   input  logic       pre_img_hsync,
   input  logic       pre_img_valid,
   input  logic [7:0] pre_img_data,
   output logic       post_img_vsync,
   output logic       post_img_hsync,
   output logic       post_img_valid,
   output logic [7:0] post_img_data
);

   localparam int COL_W = $clog2(IMG_WIDTH_MAX) + 1;
   localparam int ADR_W = COL_W - 1;

   typedef enum logic [1:0] {S_IDLE, S_FRAME, S_FLUSH} state_t;

   state_t           state, state_nxt;

   logic             lb0 [IMG_WIDTH_MAX];
   logic             lb1 [IMG_WIDTH_MAX];

   logic [COL_W-1:0] col_cnt, width_reg, flush_cnt;
   logic [15:0]      row_cnt;
   logic             vs_q, hs_q, vs_d1, vs_d2;
   logic             flush_done;

   logic             s1_valid, s1_emit, s1_first, s1_last;
   logic [2:0]       s1_vec;
   logic [2:0]       win1, win2;
   logic             out_valid, out_last, out_hsync, out_bit;

   logic             pix_bin, vs_rise, vs_fall, hs_fall;
   logic             pix_take, flush_rd, flush_end, top_en;
   logic [ADR_W-1:0] rd_addr;
   logic             rd0, rd1;

`ifdef BIN_DILATE_THRESH_EN
   localparam logic [7:0] THRESH_B = 8'(THRESH);
   assign pix_bin = (pre_img_data >= THRESH_B);
`else
   logic unused_thresh;
   assign unused_thresh = ^8'(THRESH);
   assign pix_bin       = |pre_img_data;
`endif

   assign vs_rise   = pre_img_vsync & ~vs_q;
   assign vs_fall   = ~pre_img_vsync & vs_q;
   assign hs_fall   = (state == S_FRAME) & hs_q & ~pre_img_hsync;
   assign pix_take  = (state == S_FRAME) & pre_img_hsync & pre_img_valid
                      & (col_cnt < COL_W'(IMG_WIDTH_MAX));
   assign flush_rd  = (state == S_FLUSH) & ~flush_done & (flush_cnt < width_reg);
   assign flush_end = (state == S_FLUSH) & ~flush_done & (flush_cnt == width_reg);
   assign rd_addr   = (state == S_FLUSH) ? flush_cnt[ADR_W-1:0] : col_cnt[ADR_W-1:0];
   assign rd0       = lb0[rd_addr];
   assign rd1       = lb1[rd_addr];
   // The row above the window's centre only exists once two input rows have been seen.
   assign top_en    = (row_cnt >= 16'd2);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (vs_rise) state_nxt = S_FRAME;
         S_FRAME: if (vs_fall) state_nxt = (row_cnt != 16'd0 || hs_fall) ? S_FLUSH : S_IDLE;
         S_FLUSH: if (flush_done && !s1_valid) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: the line buffers carry no reset; stale rows are masked by top_en and row-0 suppression.
   always_ff @(posedge clk) begin
      if (pix_take) begin
         lb1[rd_addr] <= rd0;
         lb0[rd_addr] <= pix_bin;
      end
   end

   // NOTE: all state updates use non-blocking assignments so stage order inside the block is irrelevant.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // vs_q starts high so a vsync still high after reset is not taken as a rise.
         vs_q       <= 1'b1;
         hs_q       <= 1'b0;
         vs_d1      <= 1'b0;
         vs_d2      <= 1'b0;
         col_cnt    <= '0;
         width_reg  <= '0;
         row_cnt    <= '0;
         flush_cnt  <= '0;
         flush_done <= 1'b0;
         s1_valid   <= 1'b0;
         s1_emit    <= 1'b0;
         s1_first   <= 1'b0;
         s1_last    <= 1'b0;
         s1_vec     <= '0;
         win1       <= '0;
         win2       <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_hsync  <= 1'b0;
         out_bit    <= 1'b0;
      end else begin
         vs_q  <= pre_img_vsync;
         hs_q  <= pre_img_hsync;
         vs_d1 <= (state_nxt == S_FRAME);
         vs_d2 <= vs_d1;

         if (state == S_IDLE && vs_rise) row_cnt <= '0;

         if (hs_fall) begin
            col_cnt   <= '0;
            width_reg <= col_cnt;
            row_cnt   <= row_cnt + 16'd1;
         end else if (pix_take) begin
            col_cnt <= col_cnt + COL_W'(1);
         end

         if (state == S_FLUSH) begin
            if (flush_rd)  flush_cnt  <= flush_cnt + COL_W'(1);
            if (flush_end) flush_done <= 1'b1;
         end else begin
            flush_cnt  <= '0;
            flush_done <= 1'b0;
         end

         // Stage 1: registered line-buffer read forms the column vector {r-1, r, r+1}.
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         if (pix_take) begin
            s1_valid <= 1'b1;
            s1_vec   <= {rd1 & top_en, rd0, pix_bin};
            s1_emit  <= (row_cnt != 16'd0);
            s1_first <= (col_cnt == '0);
         end else if (hs_fall || flush_end) begin
            s1_valid <= 1'b1;
            s1_vec   <= '0;
            s1_emit  <= hs_fall ? (row_cnt != 16'd0 && col_cnt != '0) : (width_reg != '0);
            s1_first <= 1'b0;
            s1_last  <= 1'b1;
         end else if (flush_rd) begin
            s1_valid <= 1'b1;
            s1_vec   <= {rd1 & top_en, rd0, 1'b0};
            s1_emit  <= 1'b1;
            s1_first <= (flush_cnt == '0);
         end

         // Stage 2: OR the 3x3 window; the window is emptied after each closing column.
         out_valid <= s1_valid & s1_emit & ~s1_first;
         out_last  <= s1_valid & s1_last;
         if (s1_valid) begin
            out_bit <= |{win2, win1, s1_vec};
            if (s1_last) begin
               win1 <= '0;
               win2 <= '0;
            end else begin
               win2 <= s1_first ? 3'b000 : win1;
               win1 <= s1_vec;
            end
         end

         if (s1_valid && s1_emit && !s1_first) out_hsync <= 1'b1;
         else if (out_valid && out_last)       out_hsync <= 1'b0;
      end
   end

   assign post_img_vsync = vs_d2 | (state == S_FLUSH);
   assign post_img_hsync = out_hsync;
   assign post_img_valid = out_valid;
   assign post_img_data  = {8{out_bit}};

endmodule

// File: tb/tb_bin_dilate.sv
// Scoreboard bench for bin_dilate: expected pixels are queued as stimulus is driven
// and popped as the DUT emits them; latency and framing are checked alongside.
`timescale 1ns/1ps
module tb_bin_dilate;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pre_img_vsync = 1'b0;
   logic       pre_img_hsync = 1'b0;
   logic       pre_img_valid = 1'b0;
   logic [7:0] pre_img_data = 8'h00;
   logic       post_img_vsync, post_img_hsync, post_img_valid;
   logic [7:0] post_img_data;

   bin_dilate #(.IMG_WIDTH_MAX(1024), .THRESH(128)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pre_img_vsync  (pre_img_vsync),
      .pre_img_hsync  (pre_img_hsync),
      .pre_img_valid  (pre_img_valid),
      .pre_img_data   (pre_img_data),
      .post_img_vsync (post_img_vsync),
      .post_img_hsync (post_img_hsync),
      .post_img_valid (post_img_valid),
      .post_img_data  (post_img_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      int data;
      int cyc;
      int col;
      int w;
   } exp_t;

   exp_t       sb [$];
   exp_t       mon_e;
   logic [7:0] img [8][8];
   int         cur_w, cur_h;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_errors = 0;
   int         out_cnt, hs_pulses, last_valid_cyc;
   bit         eol_prev = 1'b0;
   bit         hs_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit bin(input logic [7:0] p);
`ifdef BIN_DILATE_THRESH_EN
      return p >= 8'd128;
`else
      return p != 8'd0;
`endif
   endfunction

   function automatic int gold(input int r, input int c);
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            if (r + dr >= 0 && r + dr < cur_h && c + dc >= 0 && c + dc < cur_w)
               if (bin(img[r+dr][c+dc])) return 255;
      return 0;
   endfunction

   task automatic push(input int r, input int c, input int ecyc);
      exp_t e;
      e.data = gold(r, c);
      e.cyc  = ecyc;
      e.col  = c;
      e.w    = cur_w;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [7:0] v);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            img[r][c] = v;
   endtask

   // Output monitor: pops the scoreboard on every valid, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (eol_prev) check("hsync_fall", int'(post_img_hsync), 0);
         eol_prev = 1'b0;
         if (post_img_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", int'(post_img_valid), 0);
            end else begin
               mon_e = sb.pop_front();
               check("pix", int'(post_img_data), mon_e.data);
               if (mon_e.cyc >= 0) check("latency", cyc, mon_e.cyc);
               check("hsync_high", int'(post_img_hsync), 1);
               eol_prev = (mon_e.col == mon_e.w - 1);
            end
            out_cnt++;
            last_valid_cyc = cyc;
         end
         if (post_img_hsync && !hs_prev) hs_pulses++;
         hs_prev = post_img_hsync;
      end
   end

   task automatic do_abort();
      pre_img_valid = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      sb.delete();
      @(negedge clk);
      check("midrst_valid", int'(post_img_valid), 0);
      check("midrst_hsync", int'(post_img_hsync), 0);
      check("midrst_vsync", int'(post_img_vsync), 0);
      check("midrst_data",  int'(post_img_data), 0);
      step();
      // vsync is still high: this traffic must be ignored until a fresh vsync rise.
      pre_img_hsync = 1'b1;
      pre_img_valid = 1'b1;
      pre_img_data  = 8'hFF;
      repeat (4) step();
      pre_img_hsync = 1'b0;
      pre_img_valid = 1'b0;
      pre_img_vsync = 1'b0;
      repeat (5) step();
      check("midrst_idle_vsync", int'(post_img_vsync), 0);
   endtask

   task automatic drive_frame(input int w, input int h, input bit gaps, input int abort_row);
      int i;
      cur_w     = w;
      cur_h     = h;
      out_cnt   = 0;
      hs_pulses = 0;
      pre_img_vsync = 1'b1;
      repeat (3) step();
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            if (r == abort_row && c == 2) begin
               do_abort();
               return;
            end
            pre_img_hsync = 1'b1;
            pre_img_valid = 1'b1;
            pre_img_data  = img[r][c];
            if (r >= 1 && c >= 1) push(r - 1, c - 1, cyc + 2);
            step();
            if (gaps) begin
               pre_img_valid = 1'b0;
               pre_img_data  = 8'h5A;
               step();
            end
         end
         pre_img_valid = 1'b0;
         pre_img_hsync = 1'b0;
         if (r >= 1) push(r - 1, w - 1, cyc + 2);
         repeat (3) step();
      end
      pre_img_vsync = 1'b0;
      for (int c = 0; c < w; c++) push(h - 1, c, -1);
      for (i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!post_img_vsync) break;
      end
      check("post_vsync_low", int'(post_img_vsync), 0);
      check("vsync_fall_cycle", cyc, last_valid_cyc + 1);
      check("out_count", out_cnt, w * h);
      check("hsync_pulses", hs_pulses, h);
      check("sb_left", sb.size(), 0);
      step();
   endtask

   initial begin
      repeat (3) step();
      @(negedge clk);
      check("rst_valid", int'(post_img_valid), 0);
      check("rst_hsync", int'(post_img_hsync), 0);
      check("rst_vsync", int'(post_img_vsync), 0);
      check("rst_data",  int'(post_img_data), 0);
      step();
      rst_n = 1'b1;
      repeat (2) step();

      fill(8'h00);
      drive_frame(4, 3, 1'b0, -1);

      fill(8'h00);
      img[2][2] = 8'hFF;
      drive_frame(5, 5, 1'b0, -1);

      fill(8'h00);
      img[0][0] = 8'hFF;
      img[4][4] = 8'hFF;
      drive_frame(5, 5, 1'b0, -1);

      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            img[r][c] = ((r * 3 + c * 5) % 7 == 0) ? 8'hFF : 8'h00;
      drive_frame(8, 4, 1'b0, -1);
      drive_frame(8, 4, 1'b1, -1);

      fill(8'h00);
      img[2][2] = 8'hFF;
      drive_frame(5, 5, 1'b0, 2);
      drive_frame(5, 5, 1'b0, -1);

      fill(8'd127);
      drive_frame(4, 3, 1'b0, -1);
      fill(8'd128);
      drive_frame(4, 3, 1'b0, -1);
      fill(8'd0);
      drive_frame(4, 3, 1'b0, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish within 1 ms");
      $fatal(1, "simulation time limit reached");
   end

endmodule
